// File: rtl/phoneme_seq_pkg.sv
// Shared types and default sizing for the phoneme playback sequencer.
package phoneme_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_FETCH    = 3'd2,
    ST_WAIT_MEM = 3'd3,
    ST_PLAY     = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam int DEF_ADDR_W     = 24;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_SAMPLE_W   = 8;
  localparam int DEF_LANES      = DEF_DATA_W / DEF_SAMPLE_W;
  localparam int DEF_BYTE_SHIFT = $clog2(DEF_DATA_W / 8);

  // Right-shift that turns a byte address into a word address.
  function automatic int byte_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/phoneme_playback_seq_tick_edge_sync.sv
// Brings the audio-rate tick into clk_50 and emits one pulse per rising edge.
module tick_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchroniser followed by a history flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/phoneme_playback_seq.sv
// Plays a byte-addressed sample segment from word memory, one sample per audio tick.
// Optional macro PHONEME_LOOP_EN adds the loop input for continuous segment replay.
module phoneme_playback_seq
  import phoneme_seq_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clk_50,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_address,
  input  logic [ADDR_W-1:0]   end_address,
  input  logic                reverse,
  input  logic                pause,
  input  logic                sample_tick,
`ifdef PHONEME_LOOP_EN
  input  logic                loop,
`endif
  output logic                mem_read,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_valid,
  input  logic [DATA_W-1:0]   mem_data,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                start_ack,
  output logic                busy,
  output logic                seg_done
);

  localparam int LANES  = DATA_W / SAMPLE_W;
  localparam int BSHIFT = byte_shift(DATA_W);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
  localparam logic [ADDR_W-1:0] WORD_ONE  = ADDR_W'(1);

  state_e                       state_q, state_d;
  logic [ADDR_W-1:0]            sw_q, sw_d;
  logic [ADDR_W-1:0]            ew_q, ew_d;
  logic                         rev_q, rev_d;
  logic [ADDR_W-1:0]            cur_q, cur_d;
  logic [DATA_W-1:0]            word_q, word_d;
  logic [LANE_W-1:0]            lane_q, lane_d;
  logic [SAMPLE_W-1:0]          sample_out_q, sample_out_d;
  logic                         sample_valid_q, sample_valid_d;
  logic                         start_ack_q, start_ack_d;
  logic                         seg_done_q, seg_done_d;
  logic                         mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
  logic                         busy_q;

  logic                         tick_edge_s;
  logic [ADDR_W-1:0]            first_w_s;
  logic [ADDR_W-1:0]            last_w_s;
  logic [LANE_W-1:0]            lane_idx_s;
  logic [LANES-1:0][SAMPLE_W-1:0] lanes_s;

  tick_edge_sync u_tick (
    .clk_i   (clk_50),
    .rst_i   (rst),
    .async_i (sample_tick),
    .pulse_o (tick_edge_s)
  );

  // Reverse playback walks words from the end bound down and lanes from the top down.
  assign first_w_s  = rev_q ? ew_q : sw_q;
  assign last_w_s   = rev_q ? sw_q : ew_q;
  assign lane_idx_s = rev_q ? (LAST_LANE - lane_q) : lane_q;
  assign lanes_s    = word_q;

  // Next-state and next-output decode for the playback sequencer.
  always_comb begin
    state_d        = state_q;
    sw_d           = sw_q;
    ew_d           = ew_q;
    rev_d          = rev_q;
    cur_d          = cur_q;
    word_d         = word_q;
    lane_d         = lane_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    start_ack_d    = 1'b0;
    seg_done_d     = 1'b0;
    mem_read_d     = 1'b0;
    mem_addr_d     = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          start_ack_d = 1'b1;
          sw_d        = start_address >> BSHIFT;
          ew_d        = end_address >> BSHIFT;
          rev_d       = reverse;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (ew_q < sw_q) begin
          state_d = ST_DONE;
        end else begin
          cur_d   = first_w_s;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_read_d = 1'b1;
        mem_addr_d = cur_q;
        state_d    = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        if (mem_valid) begin
          word_d  = mem_data;
          lane_d  = '0;
          state_d = ST_PLAY;
        end else begin
          state_d = ST_WAIT_MEM;
        end
      end
      ST_PLAY: begin
        // Ticks arriving while paused are dropped, leaving lane and word untouched.
        if (tick_edge_s && !pause) begin
          sample_out_d   = lanes_s[lane_idx_s];
          sample_valid_d = 1'b1;
          if (lane_q == LAST_LANE) begin
            if (cur_q == last_w_s) begin
`ifdef PHONEME_LOOP_EN
              if (loop) begin
                seg_done_d = 1'b1;
                cur_d      = first_w_s;
                state_d    = ST_FETCH;
              end else begin
                state_d = ST_DONE;
              end
`else
              state_d = ST_DONE;
`endif
            end else begin
              cur_d   = rev_q ? (cur_q - WORD_ONE) : (cur_q + WORD_ONE);
              state_d = ST_FETCH;
            end
          end else begin
            lane_d = lane_q + LANE_ONE;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_DONE: begin
        seg_done_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      sw_q           <= '0;
      ew_q           <= '0;
      rev_q          <= 1'b0;
      cur_q          <= '0;
      word_q         <= '0;
      lane_q         <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      start_ack_q    <= 1'b0;
      seg_done_q     <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_addr_q     <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sw_q           <= sw_d;
      ew_q           <= ew_d;
      rev_q          <= rev_d;
      cur_q          <= cur_d;
      word_q         <= word_d;
      lane_q         <= lane_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      start_ack_q    <= start_ack_d;
      seg_done_q     <= seg_done_d;
      mem_read_q     <= mem_read_d;
      mem_addr_q     <= mem_addr_d;
      busy_q         <= (state_d != ST_IDLE);
    end
  end

  assign mem_read     = mem_read_q;
  assign mem_addr     = mem_addr_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign start_ack    = start_ack_q;
  assign seg_done     = seg_done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_phoneme_playback_seq.sv
// Directed self-checking bench for phoneme_playback_seq (loop scenario under PHONEME_LOOP_EN).
module tb_phoneme_playback_seq;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] start_address;
  logic [23:0] end_address;
  logic        reverse;
  logic        pause;
  logic        sample_tick;
`ifdef PHONEME_LOOP_EN
  logic        loop;
`endif
  logic        mem_read;
  logic [23:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        start_ack;
  logic        busy;
  logic        seg_done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  samp_log [0:255];
  logic [23:0] rd_log   [0:255];
  int samp_n = 0;
  int rd_n   = 0;
  int done_n = 0;
  int ack_n  = 0;

  phoneme_playback_seq dut (
    .clk_50        (clk_50),
    .rst           (rst),
    .start         (start),
    .start_address (start_address),
    .end_address   (end_address),
    .reverse       (reverse),
    .pause         (pause),
    .sample_tick   (sample_tick),
`ifdef PHONEME_LOOP_EN
    .loop          (loop),
`endif
    .mem_read      (mem_read),
    .mem_addr      (mem_addr),
    .mem_valid     (mem_valid),
    .mem_data      (mem_data),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .start_ack     (start_ack),
    .busy          (busy),
    .seg_done      (seg_done)
  );

  always #5 clk_50 = ~clk_50;

  // Memory image: every byte holds the low 8 bits of its own byte address.
  function automatic logic [31:0] mem_word(input logic [23:0] wa);
    logic [23:0] b;
    b = wa << 2;
    return {b[7:0] + 8'd3, b[7:0] + 8'd2, b[7:0] + 8'd1, b[7:0]};
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk_50) begin
    if (sample_valid && samp_n < 256) begin
      samp_log[samp_n] <= sample_out;
      samp_n <= samp_n + 1;
    end
    if (mem_read && rd_n < 256) begin
      rd_log[rd_n] <= mem_addr;
      rd_n <= rd_n + 1;
    end
    if (seg_done) done_n <= done_n + 1;
    if (start_ack) ack_n <= ack_n + 1;
  end

  // Memory responder: data returns one cycle after the read request.
  initial begin
    logic [23:0] a;
    mem_valid = 1'b0;
    mem_data  = 32'h0;
    forever begin
      @(negedge clk_50);
      if (mem_read) begin
        a = mem_addr;
        @(negedge clk_50);
        mem_valid = 1'b1;
        mem_data  = mem_word(a);
        @(negedge clk_50);
        mem_valid = 1'b0;
        mem_data  = 32'h0;
      end
    end
  end

  task automatic do_start(input logic [23:0] sa, input logic [23:0] ea, input logic rv);
    @(negedge clk_50);
    start = 1'b1; start_address = sa; end_address = ea; reverse = rv;
    @(negedge clk_50);
    start = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sample_tick = 1'b1;
      repeat (4) @(negedge clk_50);
      sample_tick = 1'b0;
      repeat (4) @(negedge clk_50);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy !== 1'b0; i++) @(negedge clk_50);
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL wait_idle busy=%b required 0 (timeout)", busy);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_address = 24'h0; end_address = 24'h0;
    reverse = 1'b0; pause = 1'b0; sample_tick = 1'b0;
`ifdef PHONEME_LOOP_EN
    loop = 1'b0;
`endif
    repeat (3) @(negedge clk_50);
    checks++;
    if ({busy, mem_read, sample_valid, start_ack, seg_done} !== 5'b0 ||
        sample_out !== 8'h00 || mem_addr !== 24'h0) begin
      $display("FAIL reset_state flags=%b%b%b%b%b out=%h addr=%h required all 0",
               busy, mem_read, sample_valid, start_ack, seg_done, sample_out, mem_addr);
      errors++;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk_50);
  endtask

  task automatic test_forward();
    int s0, r0, d0;
    s0 = samp_n; r0 = rd_n; d0 = done_n;
    do_start(24'h000010, 24'h00001F, 1'b0);
    checks++;
    if (start_ack !== 1'b1) begin
      $display("FAIL fwd_ack start_ack=%b required 1", start_ack); errors++;
    end
    repeat (6) @(negedge clk_50);
    ticks(16);
    wait_idle();
    checks++;
    if (rd_n - r0 !== 4) begin
      $display("FAIL fwd_reads count=%0d required 4", rd_n - r0); errors++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_log[r0 + i] !== 24'h4 + 24'(i)) begin
        $display("FAIL fwd_addr[%0d] got=%h required %h", i, rd_log[r0 + i], 24'h4 + 24'(i));
        errors++;
      end
    end
    checks++;
    if (samp_n - s0 !== 16) begin
      $display("FAIL fwd_samples count=%0d required 16", samp_n - s0); errors++;
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (samp_log[s0 + i] !== 8'h10 + 8'(i)) begin
        $display("FAIL fwd_sample[%0d] got=%h required %h", i, samp_log[s0 + i], 8'h10 + 8'(i));
        errors++;
      end
    end
    checks++;
    if (done_n - d0 !== 1) begin
      $display("FAIL fwd_seg_done count=%0d required 1", done_n - d0); errors++;
    end
    checks++;
    if (sample_out !== 8'h1F) begin
      $display("FAIL fwd_hold sample_out=%h required 1f", sample_out); errors++;
    end
  endtask

  task automatic test_reverse();
    int s0, r0, d0;
    s0 = samp_n; r0 = rd_n; d0 = done_n;
    do_start(24'h000010, 24'h00001F, 1'b1);
    repeat (6) @(negedge clk_50);
    ticks(16);
    wait_idle();
    checks++;
    if (rd_n - r0 !== 4) begin
      $display("FAIL rev_reads count=%0d required 4", rd_n - r0); errors++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_log[r0 + i] !== 24'h7 - 24'(i)) begin
        $display("FAIL rev_addr[%0d] got=%h required %h", i, rd_log[r0 + i], 24'h7 - 24'(i));
        errors++;
      end
    end
    checks++;
    if (samp_n - s0 !== 16) begin
      $display("FAIL rev_samples count=%0d required 16", samp_n - s0); errors++;
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (samp_log[s0 + i] !== 8'h1F - 8'(i)) begin
        $display("FAIL rev_sample[%0d] got=%h required %h", i, samp_log[s0 + i], 8'h1F - 8'(i));
        errors++;
      end
    end
    checks++;
    if (done_n - d0 !== 1) begin
      $display("FAIL rev_seg_done count=%0d required 1", done_n - d0); errors++;
    end
  endtask

  task automatic test_empty_segment();
    int r0;
    r0 = rd_n;
    do_start(24'h000010, 24'h00000C, 1'b0);
    checks++;
    if (start_ack !== 1'b1 || seg_done !== 1'b0) begin
      $display("FAIL empty_ack ack=%b done=%b required 1 0", start_ack, seg_done); errors++;
    end
    @(negedge clk_50);
    checks++;
    if (seg_done !== 1'b0) begin
      $display("FAIL empty_done_early seg_done=%b required 0", seg_done); errors++;
    end
    @(negedge clk_50);
    checks++;
    if (seg_done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL empty_done seg_done=%b busy=%b required 1 0", seg_done, busy); errors++;
    end
    repeat (3) @(negedge clk_50);
    checks++;
    if (rd_n !== r0) begin
      $display("FAIL empty_reads count=%0d required 0", rd_n - r0); errors++;
    end
  endtask

  task automatic test_pause();
    int s0, s1;
    s0 = samp_n;
    do_start(24'h000010, 24'h00001F, 1'b0);
    repeat (6) @(negedge clk_50);
    ticks(2);
    pause = 1'b1;
    repeat (2) @(negedge clk_50);
    s1 = samp_n;
    ticks(5);
    checks++;
    if (samp_n !== s1) begin
      $display("FAIL pause_strobes count=%0d required 0", samp_n - s1); errors++;
    end
    checks++;
    if (s1 - s0 !== 2) begin
      $display("FAIL pause_before count=%0d required 2", s1 - s0); errors++;
    end
    pause = 1'b0;
    ticks(14);
    wait_idle();
    checks++;
    if (samp_n - s0 !== 16) begin
      $display("FAIL pause_total count=%0d required 16", samp_n - s0); errors++;
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (samp_log[s0 + i] !== 8'h10 + 8'(i)) begin
        $display("FAIL pause_sample[%0d] got=%h required %h", i, samp_log[s0 + i], 8'h10 + 8'(i));
        errors++;
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int s0, a0;
    bit seen;
    seen = 1'b0;
    do_start(24'h000010, 24'h00001F, 1'b0);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_50);
      if (mem_read) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      $display("FAIL rstwait_read mem_read never seen required 1"); errors++;
    end
    rst = 1'b1;
    @(negedge clk_50);
    rst = 1'b0;
    s0 = samp_n; a0 = ack_n;
    repeat (3) @(negedge clk_50);
    checks++;
    if (busy !== 1'b0 || sample_out !== 8'h00) begin
      $display("FAIL rstwait_state busy=%b out=%h required 0 00", busy, sample_out); errors++;
    end
    ticks(3);
    checks++;
    if (samp_n !== s0 || busy !== 1'b0 || ack_n !== a0) begin
      $display("FAIL rstwait_quiet strobes=%0d busy=%b acks=%0d required 0 0 0",
               samp_n - s0, busy, ack_n - a0);
      errors++;
    end
    test_forward();
  endtask

  task automatic test_rst_with_start();
    int a0;
    a0 = ack_n;
    @(negedge clk_50);
    rst = 1'b1; start = 1'b1; start_address = 24'h10; end_address = 24'h1F; reverse = 1'b0;
    @(negedge clk_50);
    rst = 1'b0; start = 1'b0;
    @(negedge clk_50);
    checks++;
    if (busy !== 1'b0 || ack_n !== a0) begin
      $display("FAIL rst_start busy=%b acks=%0d required 0 0", busy, ack_n - a0); errors++;
    end
  endtask

`ifdef PHONEME_LOOP_EN
  task automatic test_loop();
    int s0, r0, d0;
    s0 = samp_n; r0 = rd_n; d0 = done_n;
    loop = 1'b1;
    do_start(24'h000010, 24'h000013, 1'b0);
    repeat (6) @(negedge clk_50);
    ticks(8);
    checks++;
    if (done_n - d0 !== 2 || busy !== 1'b1) begin
      $display("FAIL loop_done count=%0d busy=%b required 2 1", done_n - d0, busy); errors++;
    end
    loop = 1'b0;
    ticks(4);
    wait_idle();
    checks++;
    if (done_n - d0 !== 3 || rd_n - r0 !== 3 || samp_n - s0 !== 12) begin
      $display("FAIL loop_totals done=%0d reads=%0d samples=%0d required 3 3 12",
               done_n - d0, rd_n - r0, samp_n - s0);
      errors++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_log[r0 + i] !== 24'h4) begin
        $display("FAIL loop_addr[%0d] got=%h required 000004", i, rd_log[r0 + i]); errors++;
      end
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (samp_log[s0 + i] !== 8'h10 + 8'(i % 4)) begin
        $display("FAIL loop_sample[%0d] got=%h required %h", i, samp_log[s0 + i], 8'h10 + 8'(i % 4));
        errors++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_empty_segment();
    test_pause();
    test_reset_in_wait();
    test_rst_with_start();
`ifdef PHONEME_LOOP_EN
    test_loop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phoneme_playback_seq.md
PHONEME_PLAYBACK_SEQ -- requirements
Module: phoneme_playback_seq

Interface
REQ-001 Parameter ADDR_W, default 24, byte/word address width.
REQ-002 Parameter DATA_W, default 32, memory word width; SHALL be a multiple of SAMPLE_W and a power-of-two number of bytes.
REQ-003 Parameter SAMPLE_W, default 8, audio sample width; LANES = DATA_W/SAMPLE_W.
REQ-004 clk_50  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request to play segment [start_address, end_address].
REQ-007 start_address, end_address  in  ADDR_W  byte addresses, inclusive; sampled only when start is accepted.
REQ-008 reverse  in  1  playback direction, sampled with start.
REQ-009 pause  in  1  level; holds playback.
REQ-010 sample_tick  in  1  asynchronous audio-rate clock (clk_song).
REQ-011 mem_read  out  1  one-cycle read request; mem_addr  out  ADDR_W  word address.
REQ-012 mem_valid  in  1  read complete; mem_data  in  DATA_W  word, valid while mem_valid.
REQ-013 sample_out  out  SAMPLE_W; sample_valid  out  1  one-cycle strobe.
REQ-014 start_ack  out  1  pulse on accepted start; busy  out  1; seg_done  out  1  pulse.

Function
REQ-015 States IDLE, LOAD, FETCH, WAIT_MEM, PLAY, DONE; busy=1 in all but IDLE.
REQ-016 IDLE: start=1 -> LOAD, start_ack=1 same cycle as transition; start while busy ignored, no ack.
REQ-017 LOAD: word addresses = byte address >> log2(DATA_W/8); cur = start_w (forward) or end_w (reverse); end_w < start_w -> DONE, no reads.
REQ-018 FETCH: mem_read=1 for exactly one cycle, mem_addr=cur -> WAIT_MEM; first word of segment is read (inclusive).
REQ-019 WAIT_MEM: on mem_valid capture mem_data into word register, lane=0 -> PLAY; waits indefinitely otherwise.
REQ-020 sample_tick passes a 2-flop synchroniser then rising-edge detect; one detected edge = one sample slot.
REQ-021 PLAY: on detected edge with pause=0, sample_valid=1 next cycle; forward emits lane 0 (LSBs) first ascending, reverse emits lane LANES-1 first descending.
REQ-022 After last lane: cur==last word -> DONE; else cur +/-1 -> FETCH.
REQ-023 Pause: edges detected while pause=1 are discarded; no sample emitted, lane and cur frozen; resumes on next edge after pause=0; pause ignored outside PLAY.
REQ-024 DONE: seg_done=1 one cycle -> IDLE.
REQ-025 sample_out holds last emitted value between strobes; reset value 0.
REQ-026 Address arithmetic ADDR_W-wide; no wrap past 0 or all-ones since traversal stops at segment bound.

Reset
REQ-027 rst=1 at any clock edge: state IDLE, mem_read, sample_valid, start_ack, seg_done, busy=0, sample_out=0, mem_addr=0, synchroniser cleared; any in-flight mem_valid ignored.
REQ-028 start and rst in same cycle: rst wins, no ack.

Configuration
REQ-029 Macro PHONEME_LOOP_EN: adds input loop (1 bit); at REQ-022 end-of-segment with loop=1, seg_done pulses and cur reloads to first word -> FETCH, busy stays 1.
REQ-030 Without PHONEME_LOOP_EN: no loop port; end-of-segment always -> DONE.

Structure
REQ-031 Package phoneme_seq_pkg: state enumeration, default widths, LANES and byte-shift constants.
REQ-032 Sub-module tick_edge_sync: 2-flop synchroniser plus rising-edge pulse, reset by rst.

Verification
REQ-033 start 0x000010..0x00001F forward, DATA_W=32: reads words 0x4,0x5,0x6,0x7; 16 samples, bytes in ascending address order; one seg_done.
REQ-034 Same segment reverse=1: reads 0x7..0x4; 16 samples in descending byte order.
REQ-035 end 0x0C, start 0x10: start_ack, seg_done 2 cycles later, zero mem_read.
REQ-036 pause=1 for 5 ticks mid-word: exactly 0 strobes during pause; remaining lanes emitted unchanged after release.
REQ-037 rst asserted in WAIT_MEM, mem_valid arrives next cycle: busy=0, no sample_valid, next start behaves as fresh.
REQ-038 PHONEME_LOOP_EN, loop=1, one-word segment: seg_done every 4 samples, same word re-read each pass.
